ps2_mouse_cursor: RTL and testbench

Converts the relative movement packets produced by the PS/2 mouse interface into an absolute, screen-clamped cursor position, a board-tile coordinate, and single-cycle click events. It sits directly downstream of `ps2_mouse_interface`, consuming `x_increment`, `y_increment`, the button levels, `data_ready` and `error_no_ack`. It feeds the game-control and VGA cursor-overlay logic.

---
 rtl/ps2_mouse_cursor.sv | 131 +++++++++++++
 tb/tb_ps2_mouse_cursor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_cursor.sv
// PS/2 relative motion to absolute, screen-clamped cursor position.
// Also produces tile coordinates, click pulses, link status and overrun.
module ps2_mouse_cursor #(
  parameter int H_MAX      = 639,
  parameter int V_MAX      = 479,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int TILE_SHIFT = 5
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  data_ready,
  input  logic [8:0]            x_increment,
  input  logic [8:0]            y_increment,
  input  logic                  left_button,
  input  logic                  right_button,
  input  logic                  error_no_ack,
  output logic [9:0]            cursor_x,
  output logic [9:0]            cursor_y,
  output logic [9-TILE_SHIFT:0] tile_col,
  output logic [9-TILE_SHIFT:0] tile_row,
  output logic                  left_click,
  output logic                  right_click,
  output logic                  moved,
  output logic                  link_ok,
  output logic                  overrun
);

  localparam int TW = 10 - TILE_SHIFT;
  localparam logic [9:0] XI = 10'(X_INIT);
  localparam logic [9:0] YI = 10'(Y_INIT);
  localparam logic signed [11:0] HM = 12'(H_MAX);
  localparam logic signed [11:0] VM = 12'(V_MAX);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    COMMIT
  } state_e;

  state_e             state_q;
  logic [8:0]         dx_q, dy_q;
  logic               lb_q, rb_q;
  logic               lbp_q, rbp_q;
  logic signed [11:0] nx_q, ny_q;
  logic [9:0]         cx_q, cy_q;
  logic [9:0]         cx_d, cy_d;
  logic [TW-1:0]      tc_q, tr_q;
  logic               lclk_q, rclk_q;
  logic               moved_q, link_q, ovr_q;

  // Saturate the signed sums into the visible screen area.
  always_comb begin
    cx_d = nx_q[9:0];
    cy_d = ny_q[9:0];
    if (nx_q < 12'sd0)   cx_d = '0;
    else if (nx_q > HM)  cx_d = HM[9:0];
    if (ny_q < 12'sd0)   cy_d = '0;
    else if (ny_q > VM)  cy_d = VM[9:0];
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      lb_q    <= 1'b0;
      rb_q    <= 1'b0;
      lbp_q   <= 1'b0;
      rbp_q   <= 1'b0;
      nx_q    <= '0;
      ny_q    <= '0;
      cx_q    <= XI;
      cy_q    <= YI;
      tc_q    <= XI[9:TILE_SHIFT];
      tr_q    <= YI[9:TILE_SHIFT];
      lclk_q  <= 1'b0;
      rclk_q  <= 1'b0;
      moved_q <= 1'b0;
      link_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      link_q  <= ~error_no_ack;
      lclk_q  <= 1'b0;
      rclk_q  <= 1'b0;
      moved_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (data_ready && !error_no_ack) begin
            dx_q    <= x_increment;
            dy_q    <= y_increment;
            lb_q    <= left_button;
            rb_q    <= right_button;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (data_ready) ovr_q <= 1'b1;
          nx_q    <= {2'b00, cx_q} + {{3{dx_q[8]}}, dx_q};
          ny_q    <= {2'b00, cy_q} - {{3{dy_q[8]}}, dy_q};
          state_q <= COMMIT;
        end
        COMMIT: begin
          if (data_ready) ovr_q <= 1'b1;
          cx_q    <= cx_d;
          cy_q    <= cy_d;
          tc_q    <= cx_d[9:TILE_SHIFT];
          tr_q    <= cy_d[9:TILE_SHIFT];
          moved_q <= (cx_d != cx_q) || (cy_d != cy_q);
          lclk_q  <= lb_q & ~lbp_q;
          rclk_q  <= rb_q & ~rbp_q;
          lbp_q   <= lb_q;
          rbp_q   <= rb_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cursor_x    = cx_q;
  assign cursor_y    = cy_q;
  assign tile_col    = tc_q;
  assign tile_row    = tr_q;
  assign left_click  = lclk_q;
  assign right_click = rclk_q;
  assign moved       = moved_q;
  assign link_ok     = link_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Directed bench for ps2_mouse_cursor with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_ps2_mouse_cursor;

  logic       clk;
  logic       rst_n;
  logic       dr;
  logic [8:0] xi, yi;
  logic       lb, rb;
  logic       nack;
  logic [9:0] cx, cy;
  logic [4:0] tc, tr;
  logic       lclk, rclk, mv, lok, ovr;

  int checks = 0;
  int errors = 0;

  ps2_mouse_cursor dut (
    .sys_clk     (clk),
    .reset_n     (rst_n),
    .data_ready  (dr),
    .x_increment (xi),
    .y_increment (yi),
    .left_button (lb),
    .right_button(rb),
    .error_no_ack(nack),
    .cursor_x    (cx),
    .cursor_y    (cy),
    .tile_col    (tc),
    .tile_row    (tr),
    .left_click  (lclk),
    .right_click (rclk),
    .moved       (mv),
    .link_ok     (lok),
    .overrun     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one packet for exactly one rising edge.
  task automatic send(input int dx, input int dy,
                      input logic l, input logic r);
    @(negedge clk);
    dr = 1'b1;
    xi = 9'(dx);
    yi = 9'(dy);
    lb = l;
    rb = r;
    @(negedge clk);
    dr = 1'b0;
  endtask

  // After send returns, the commit edge is two edges away.
  task automatic wait_commit();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_pos(input string tag, input int x, input int y);
    chk({tag, "_x"}, int'(cx), x);
    chk({tag, "_y"}, int'(cy), y);
    chk({tag, "_tc"}, int'(tc), x >> 5);
    chk({tag, "_tr"}, int'(tr), y >> 5);
  endtask

  int lexp [5] = '{1, 0, 0, 0, 1};
  int lvl  [5] = '{1, 1, 1, 0, 1};

  initial begin
    rst_n = 1'b0;
    dr = 1'b0;
    xi = '0;
    yi = '0;
    lb = 1'b0;
    rb = 1'b0;
    nack = 1'b0;
    @(negedge clk);
    chk_pos("rst", 320, 240);
    chk("rst_lclk", int'(lclk), 0);
    chk("rst_rclk", int'(rclk), 0);
    chk("rst_mv", int'(mv), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk("rst_lok", int'(lok), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lok_up", int'(lok), 1);

    // Basic move: +10 right, +5 up.
    send(10, 5, 1'b0, 1'b0);
    @(negedge clk);
    chk("basic_mv_early", int'(mv), 0);
    chk("basic_x_early", int'(cx), 320);
    @(negedge clk);
    chk_pos("basic", 330, 235);
    chk("basic_mv", int'(mv), 1);
    @(negedge clk);
    chk("basic_mv_drop", int'(mv), 0);

    // Clamping on both axes.
    do_reset();
    send(-256, -255, 1'b0, 1'b0);
    wait_commit();
    chk_pos("clamp1", 64, 479);
    chk("clamp1_mv", int'(mv), 1);
    send(-256, -255, 1'b0, 1'b0);
    wait_commit();
    chk_pos("clamp2", 0, 479);
    chk("clamp2_mv", int'(mv), 1);
    send(-256, -255, 1'b0, 1'b0);
    wait_commit();
    chk_pos("clamp3", 0, 479);
    chk("clamp3_mv", int'(mv), 0);
    send(255, 255, 1'b0, 1'b0);
    wait_commit();
    chk_pos("clamp4", 255, 224);

    // Left click edges: held button clicks once.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(0, 0, lvl[i] == 1, 1'b0);
      wait_commit();
      chk($sformatf("lclick%0d", i), int'(lclk), lexp[i]);
      chk($sformatf("rclick%0d", i), int'(rclk), 0);
      chk($sformatf("lclick_mv%0d", i), int'(mv), 0);
    end
    send(0, 0, 1'b0, 1'b1);
    wait_commit();
    chk("rclick_edge", int'(rclk), 1);
    chk("rclick_l", int'(lclk), 0);

    // Overrun: back-to-back strobes, then an N+3 packet.
    do_reset();
    @(negedge clk);
    dr = 1'b1;
    xi = 9'd5;
    yi = 9'd0;
    lb = 1'b0;
    rb = 1'b0;
    @(negedge clk);
    xi = 9'd100;
    @(negedge clk);
    dr = 1'b0;
    chk("ovr_set", int'(ovr), 1);
    @(negedge clk);
    chk("ovr_x", int'(cx), 325);
    xi = 9'd1;
    dr = 1'b1;
    @(negedge clk);
    dr = 1'b0;
    wait_commit();
    chk("ovr_n3_x", int'(cx), 326);
    chk("ovr_sticky", int'(ovr), 1);

    // Link down: packets ignored.
    do_reset();
    nack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(50, 0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (lclk || rclk || mv)
          chk("nack_pulse", int'({lclk, rclk, mv}), 0);
      end
    end
    chk("nack_x", int'(cx), 320);
    chk("nack_y", int'(cy), 240);
    chk("nack_lok", int'(lok), 0);
    nack = 1'b0;
    @(negedge clk);
    chk("nack_lok_up", int'(lok), 1);
    send(50, 0, 1'b1, 1'b0);
    wait_commit();
    chk("nack_after_x", int'(cx), 370);
    chk("nack_after_lclk", int'(lclk), 1);

    // Reset asserted while a packet is in CALC.
    do_reset();
    send(10, 10, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_pos("midrst", 320, 240);
    chk("midrst_mv", int'(mv), 0);
    chk("midrst_lok", int'(lok), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_x%0d", k), int'(cx), 320);
      chk($sformatf("midrst_p%0d", k), int'({lclk, mv}), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
